// File: rtl/xgxs_lane_sync.sv
// rtl/xgxs_lane_sync.sv - XGXS receive lane code-group synchroniser
//
// Purpose:
//   Comma-based code-group synchronisation for one XGXS lane. It counts
//   commas to acquire sync and tracks an error level while synchronised.
//   It drops sync when an invalid group arrives after the last tolerated
//   error level. It also delays the code-group stream by one cycle so that
//   sync_status lines up with it.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   cg_valid     in   cg_in / code_viol carry a new code group
//   cg_in[9:0]   in   code group, bit 9 = 'a'
//   code_viol    in   decoder flagged cg_in invalid
//   cg_out[9:0]  out  cg_in delayed one cycle (held while cg_valid=0)
//   cg_out_valid out  cg_valid delayed one cycle
//   comma_det    out  last accepted group was a valid comma
//   sync_status  out  lane synchronised
//   err_level    out  current error level, 0 = clean
//   loss_cnt     out  SYNCED->LOSS transitions, saturating (STATS only)
//   viol_cnt     out  invalid groups seen, saturating (STATS only)
//
// Configuration:
//   XGXS_LANE_SYNC_STATS_EN adds the loss_cnt and viol_cnt counters.

module xgxs_lane_sync #(
  parameter int COMMAS_TO_SYNC  = 3,
  parameter int GOOD_TO_RECOVER = 4,
  parameter int ERR_LEVELS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cg_valid,
  input  logic [9:0] cg_in,
  input  logic       code_viol,
  output logic [9:0] cg_out,
  output logic       cg_out_valid,
  output logic       comma_det,
  output logic       sync_status,
`ifdef XGXS_LANE_SYNC_STATS_EN
  output logic [15:0] loss_cnt,
  output logic [15:0] viol_cnt,
`endif
  output logic [2:0] err_level
);

  localparam logic [2:0] C2S  = 3'(COMMAS_TO_SYNC);
  localparam logic [2:0] G2R  = 3'(GOOD_TO_RECOVER);
  localparam logic [2:0] ELVL = 3'(ERR_LEVELS);

  typedef enum logic [1:0] {LOSS, DETECT, SYNCED} state_t;

  state_t     state;
  logic [2:0] comma_cnt;
  logic [2:0] good_cnt;
  logic       is_comma;
  logic       comma_ok;

  // A comma that is also flagged invalid is treated purely as invalid.
  assign is_comma = (cg_in[9:3] == 7'b0011111) || (cg_in[9:3] == 7'b1100000);
  assign comma_ok = is_comma && !code_viol;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOSS;
      comma_cnt    <= 3'd0;
      good_cnt     <= 3'd0;
      err_level    <= 3'd0;
      cg_out       <= 10'd0;
      cg_out_valid <= 1'b0;
      comma_det    <= 1'b0;
      sync_status  <= 1'b0;
`ifdef XGXS_LANE_SYNC_STATS_EN
      loss_cnt     <= 16'd0;
      viol_cnt     <= 16'd0;
`endif
    end else begin
      cg_out_valid <= cg_valid;
      if (cg_valid) begin
        cg_out    <= cg_in;
        comma_det <= comma_ok;
`ifdef XGXS_LANE_SYNC_STATS_EN
        if (code_viol && viol_cnt != 16'hFFFF) viol_cnt <= viol_cnt + 16'd1;
`endif
        case (state)
          LOSS: begin
            if (comma_ok) begin
              // With a threshold of one, the first comma is enough to lock.
              if (C2S == 3'd1) begin
                state       <= SYNCED;
                sync_status <= 1'b1;
                err_level   <= 3'd0;
                good_cnt    <= 3'd0;
                comma_cnt   <= 3'd0;
              end else begin
                state     <= DETECT;
                comma_cnt <= 3'd1;
              end
            end
          end
          DETECT: begin
            if (code_viol) begin
              state     <= LOSS;
              comma_cnt <= 3'd0;
            end else if (comma_ok) begin
              if (comma_cnt + 3'd1 == C2S) begin
                state       <= SYNCED;
                sync_status <= 1'b1;
                err_level   <= 3'd0;
                good_cnt    <= 3'd0;
                comma_cnt   <= 3'd0;
              end else begin
                comma_cnt <= comma_cnt + 3'd1;
              end
            end
          end
          SYNCED: begin
            if (err_level == 3'd0) begin
              if (code_viol) begin
                err_level <= 3'd1;
                good_cnt  <= 3'd0;
              end
            end else if (!code_viol) begin
              if (good_cnt + 3'd1 == G2R) begin
                err_level <= err_level - 3'd1;
                good_cnt  <= 3'd0;
              end else begin
                good_cnt <= good_cnt + 3'd1;
              end
            end else if (err_level == ELVL) begin
              state       <= LOSS;
              sync_status <= 1'b0;
              err_level   <= 3'd0;
              good_cnt    <= 3'd0;
              comma_cnt   <= 3'd0;
`ifdef XGXS_LANE_SYNC_STATS_EN
              if (loss_cnt != 16'hFFFF) loss_cnt <= loss_cnt + 16'd1;
`endif
            end else begin
              err_level <= err_level + 3'd1;
              good_cnt  <= 3'd0;
            end
          end
          default: begin
            state       <= LOSS;
            sync_status <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xgxs_lane_sync.sv
// tb/tb_xgxs_lane_sync.sv - scoreboard testbench for xgxs_lane_sync
module tb_xgxs_lane_sync;

  localparam int C2S  = 3;
  localparam int G2R  = 4;
  localparam int ELVL = 3;
  localparam logic [9:0] K285  = 10'b0011111010;
  localparam logic [9:0] K285N = 10'b1100000101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cg_valid = 1'b0;
  logic [9:0] cg_in = 10'd0;
  logic       code_viol = 1'b0;
  logic [9:0] cg_out;
  logic       cg_out_valid;
  logic       comma_det;
  logic       sync_status;
  logic [2:0] err_level;
`ifdef XGXS_LANE_SYNC_STATS_EN
  logic [15:0] loss_cnt;
  logic [15:0] viol_cnt;
`endif

  always #5 clk = ~clk;

  xgxs_lane_sync #(
    .COMMAS_TO_SYNC(C2S), .GOOD_TO_RECOVER(G2R), .ERR_LEVELS(ELVL)
  ) dut (
    .clk(clk), .rst(rst), .cg_valid(cg_valid), .cg_in(cg_in),
    .code_viol(code_viol), .cg_out(cg_out), .cg_out_valid(cg_out_valid),
    .comma_det(comma_det), .sync_status(sync_status),
`ifdef XGXS_LANE_SYNC_STATS_EN
    .loss_cnt(loss_cnt), .viol_cnt(viol_cnt),
`endif
    .err_level(err_level)
  );

  typedef struct packed {
    logic [9:0]  o;
    logic        ov;
    logic        cd;
    logic        ss;
    logic [2:0]  el;
    logic [15:0] lc;
    logic [15:0] vc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model: sync is "enough consecutive-ish valid commas seen",
  // then a leaky error bucket that is drained by runs of good groups.
  logic [9:0] m_out;
  bit         m_ov, m_cd, m_sync;
  int         m_commas, m_err, m_good, m_loss, m_viol;

  function automatic bit comma_rule(input logic [9:0] c);
    logic [6:0] top;
    top = c[9:3];
    return (top == 7'b0011111) || (top == 7'b1100000);
  endfunction

  task automatic model(input logic r, input logic v, input logic [9:0] c, input logic x);
    bit good_comma;
    if (r) begin
      m_out = '0; m_ov = 0; m_cd = 0; m_sync = 0;
      m_commas = 0; m_err = 0; m_good = 0; m_loss = 0; m_viol = 0;
      return;
    end
    m_ov = v;
    if (!v) return;
    m_out = c;
    good_comma = comma_rule(c) && !x;
    m_cd = good_comma;
    if (x && m_viol < 65535) m_viol++;
    if (!m_sync) begin
      if (x) m_commas = 0;
      else if (good_comma) m_commas++;
      if (m_commas == C2S) begin
        m_sync = 1; m_commas = 0; m_err = 0; m_good = 0;
      end
    end else if (x) begin
      if (m_err == ELVL) begin
        m_sync = 0; m_err = 0; m_good = 0; m_commas = 0;
        if (m_loss < 65535) m_loss++;
      end else begin
        m_err++; m_good = 0;
      end
    end else if (m_err > 0) begin
      m_good++;
      if (m_good == G2R) begin
        m_err--; m_good = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [9:0] c, input logic x);
    exp_t e;
    @(negedge clk);
    rst = r; cg_valid = v; cg_in = c; code_viol = x;
    model(r, v, c, x);
    e.o = m_out; e.ov = m_ov; e.cd = m_cd; e.ss = m_sync; e.el = 3'(m_err);
    e.lc = 16'(m_loss); e.vc = 16'(m_viol);
    q.push_back(e);
  endtask

  function automatic logic [9:0] data_cg();
    logic [9:0] c;
    c = 10'($urandom_range(0, 1023));
    while (comma_rule(c)) c = 10'($urandom_range(0, 1023));
    return c;
  endfunction

  task automatic grp(input logic [9:0] c, input logic x);
    drive(1'b0, 1'b1, c, x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
  endtask

  task automatic acquire(input int gap);
    for (int i = 0; i < C2S; i++) begin
      grp(K285, 1'b0);
      idle(gap);
      grp(data_cg(), 1'b0);
      idle(gap);
    end
  endtask

  // Monitor: every cycle after an issued stimulus, compare against the
  // oldest expectation in the scoreboard.
  initial begin
    exp_t e;
    logic [15:0] alc, avc;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
`ifdef XGXS_LANE_SYNC_STATS_EN
        alc = loss_cnt; avc = viol_cnt;
`else
        alc = e.lc; avc = e.vc;
`endif
        checks++;
        if (cg_out !== e.o || cg_out_valid !== e.ov || comma_det !== e.cd ||
            sync_status !== e.ss || err_level !== e.el || alc !== e.lc || avc !== e.vc) begin
          errors++;
          $display("FAIL outputs cycle %0d: got cg_out=%h ov=%b cd=%b ss=%b el=%0d lc=%0d vc=%0d exp cg_out=%h ov=%b cd=%b ss=%b el=%0d lc=%0d vc=%0d",
                   cycle, cg_out, cg_out_valid, comma_det, sync_status, err_level, alc, avc,
                   e.o, e.ov, e.cd, e.ss, e.el, e.lc, e.vc);
        end
      end
    end
  end

  initial begin
    // Reset with live random traffic.
    drive(1'b1, 1'b1, 10'($urandom_range(0, 1023)), 1'b0);
    drive(1'b1, 1'b1, 10'($urandom_range(0, 1023)), 1'b1);
    // Acquire with data groups between commas.
    acquire(0);
    grp(data_cg(), 1'b0);
    // Recover one error level.
    grp(data_cg(), 1'b1);
    for (int i = 0; i < G2R; i++) grp(data_cg(), 1'b0);
    grp(data_cg(), 1'b0);
    // Climb the error levels then lose sync.
    for (int k = 0; k < ELVL; k++) begin
      grp(data_cg(), 1'b1);
      grp(data_cg(), 1'b0);
      grp(data_cg(), 1'b0);
    end
    grp(data_cg(), 1'b1);
    grp(data_cg(), 1'b0);
    // Acquire with gaps in the valid stream.
    acquire(5);
    // Drop sync, then a comma+viol while detecting.
    for (int i = 0; i <= ELVL; i++) grp(data_cg(), 1'b1);
    grp(K285N, 1'b0);
    grp(K285, 1'b1);
    grp(K285, 1'b0);
    grp(data_cg(), 1'b0);
    // Mid-stream reset while synced at error level 2.
    for (int i = 0; i < C2S; i++) grp(K285, 1'b0);
    grp(data_cg(), 1'b1);
    grp(data_cg(), 1'b1);
    drive(1'b1, 1'b1, K285, 1'b0);
    grp(data_cg(), 1'b0);
    // Randomised traffic biased toward commas to exercise all states.
    for (int n = 0; n < 3000; n++) begin
      logic [9:0] c;
      if ($urandom_range(0, 2) == 0) begin
        c = ($urandom_range(0, 1) == 0) ? K285 : K285N;
        c[2:0] = 3'($urandom_range(0, 7));
      end else begin
        c = 10'($urandom_range(0, 1023));
      end
      drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
            c, 1'($urandom_range(0, 11) == 0));
    end
    // Let the monitor drain the scoreboard, bounded.
    for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
